relu_writeback: RTL

- Output stage of the SMAC writeback path.
- Captures one group of up to 4 signed accumulator results from the MAC array and applies ReLU, a programmable right shift and unsigned saturation to each lane.
- Streams the results one lane per handshake to the output memory interface, with lane index and a last-lane flag.
- Internal lane sequencing replaces the external ReLU mux-select counter for this path.

---
 rtl/relu_writeback.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/relu_writeback.sv
// Writeback output stage: captures a group of up to four signed accumulators and streams
// ReLU + shift + unsigned-saturate results one lane per handshake. Optional counters: RELU_STATS_EN.
module relu_writeback #(
    parameter int ACC_W = 24,
    parameter int OUT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               acc_valid,
    output logic               acc_ready,
    input  logic [4*ACC_W-1:0] acc_data,
    input  logic [2:0]         num_lanes,
    input  logic [4:0]         shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [1:0]         out_lane,
    output logic               out_last,
    output logic               busy
`ifdef RELU_STATS_EN
    ,
    input  logic               stats_clear,
    output logic [15:0]        zero_cnt,
    output logic [15:0]        sat_cnt
`endif
);

    // Handshakes: a group moves on acc_valid && acc_ready, an element on out_valid && out_ready;
    // a presented element and its lane/last flags stay stable until that handshake.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                r_state;
    logic [4*ACC_W-1:0]    r_acc;
    logic [4:0]            r_shift;
    logic [2:0]            r_lanes;
    logic                  r_acc_ready;
    logic                  r_out_valid;
    logic [OUT_W-1:0]      r_out_data;
    logic [1:0]            r_out_lane;
    logic                  r_out_last;
    logic                  r_busy;

    logic [2:0]            w_in_lanes;
    logic [1:0]            w_nxt_lane;
    logic [ACC_W-1:0]      w_nxt_v;
    logic                  w_at_last;

    function automatic logic [ACC_W-1:0] shr(input logic [ACC_W-1:0] v, input logic [4:0] sh);
        if (int'(sh) >= ACC_W) return '0;
        return v >> sh;
    endfunction

    function automatic logic [OUT_W-1:0] relu_f(input logic [ACC_W-1:0] v, input logic [4:0] sh);
        logic [ACC_W-1:0] s;
        s = shr(v, sh);
        if (v[ACC_W-1]) return '0;
        if (|s[ACC_W-1:OUT_W]) return '1;
        return s[OUT_W-1:0];
    endfunction

    // Zero or out-of-range lane counts mean a full group.
    assign w_in_lanes = (num_lanes == 3'd0 || num_lanes > 3'd4) ? 3'd4 : num_lanes;
    assign w_nxt_lane = r_out_lane + 2'd1;
    assign w_nxt_v    = r_acc[int'(w_nxt_lane)*ACC_W +: ACC_W];
    assign w_at_last  = ({1'b0, r_out_lane} == r_lanes - 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_shift     <= '0;
            r_lanes     <= '0;
            r_acc_ready <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_lane  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (acc_valid) begin
                        r_acc       <= acc_data;
                        r_shift     <= shift;
                        r_lanes     <= w_in_lanes;
                        r_out_lane  <= 2'd0;
                        r_out_data  <= relu_f(acc_data[ACC_W-1:0], shift);
                        r_out_last  <= (w_in_lanes == 3'd1);
                        r_out_valid <= 1'b1;
                        r_acc_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (w_at_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_acc_ready <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_out_lane  <= w_nxt_lane;
                            r_out_data  <= relu_f(w_nxt_v, r_shift);
                            r_out_last  <= ({1'b0, w_nxt_lane} == r_lanes - 3'd1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign acc_ready = r_acc_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_lane  = r_out_lane;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

`ifdef RELU_STATS_EN
    logic [15:0]      r_zero_cnt;
    logic [15:0]      r_sat_cnt;
    logic             w_hs;
    logic [ACC_W-1:0] w_cur_v;
    logic [ACC_W-1:0] w_cur_s;
    logic             w_cur_neg;
    logic             w_cur_sat;

    // Classify the lane being handed off from the captured copy, not the live input.
    assign w_hs      = r_out_valid && out_ready;
    assign w_cur_v   = r_acc[int'(r_out_lane)*ACC_W +: ACC_W];
    assign w_cur_s   = shr(w_cur_v, r_shift);
    assign w_cur_neg = w_cur_v[ACC_W-1];
    assign w_cur_sat = !w_cur_neg && (|w_cur_s[ACC_W-1:OUT_W]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero_cnt <= '0;
            r_sat_cnt  <= '0;
        end else if (stats_clear) begin
            r_zero_cnt <= '0;
            r_sat_cnt  <= '0;
        end else if (w_hs) begin
            if (w_cur_neg && r_zero_cnt != 16'hFFFF) r_zero_cnt <= r_zero_cnt + 16'd1;
            if (w_cur_sat && r_sat_cnt != 16'hFFFF)  r_sat_cnt  <= r_sat_cnt + 16'd1;
        end
    end

    assign zero_cnt = r_zero_cnt;
    assign sat_cnt  = r_sat_cnt;
`endif

endmodule
